// File: rtl/signed_cast_round_if.sv
// Streaming handshake bundle for signed_cast_round: input words, output words,
// per-lane clip warnings and sticky overflow status.
interface signed_cast_round_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 8,
  parameter int CHANNELS   = 1
);
  logic [CHANNELS*DIN_WIDTH-1:0]  din;
  logic                           din_valid;
  logic                           din_ready;
  logic [CHANNELS*DOUT_WIDTH-1:0] dout;
  logic                           dout_valid;
  logic                           dout_ready;
  logic [2*CHANNELS-1:0]          warning;
  logic [CHANNELS-1:0]            ovf_sticky;
  logic                           ovf_clear;

  modport master (
    output din, din_valid, dout_ready, ovf_clear,
    input  din_ready, dout, dout_valid, warning, ovf_sticky
  );

  modport slave (
    input  din, din_valid, dout_ready, ovf_clear,
    output din_ready, dout, dout_valid, warning, ovf_sticky
  );
endinterface

// File: rtl/signed_cast_round.sv
// Multi-lane signed fixed-point converter: stage 1 aligns and rounds into a
// carry-safe intermediate, stage 2 saturates exactly to the output format.
module signed_cast_round #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_POINT  = 12,
  parameter int DOUT_WIDTH = 8,
  parameter int DOUT_POINT = 4,
  parameter int CHANNELS   = 1,
  parameter int ROUND_MODE = 0,
  parameter int SYMMETRIC  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  signed_cast_round_if.slave bus
);
  localparam int S  = DIN_POINT - DOUT_POINT;
  // One spare bit above the aligned value so the rounding carry never wraps.
  localparam int IW = DIN_WIDTH - S + 1;
  localparam int CW = ((IW > DOUT_WIDTH) ? IW : DOUT_WIDTH) + 1;
  localparam logic signed [CW-1:0] MAX_V =
    {{(CW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_FULL =
    {{(CW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic signed [CW-1:0] MIN_V =
    (SYMMETRIC != 0) ? (MIN_FULL | CW'(1)) : MIN_FULL;

  logic w_en;
  logic w_xfer_out;
  logic r_s1_valid;
  logic r_dout_valid;

  assign w_en           = ~r_dout_valid | bus.dout_ready;
  assign w_xfer_out     = r_dout_valid & bus.dout_ready;
  assign bus.din_ready  = w_en;
  assign bus.dout_valid = r_dout_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_dout_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid   <= bus.din_valid;
      r_dout_valid <= r_s1_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic signed [DIN_WIDTH-1:0] w_x;
      logic signed [IW-1:0]        w_aligned;
      logic signed [IW-1:0]        r_s1_val;
      logic signed [CW-1:0]        w_v;
      logic                        w_hi;
      logic                        w_lo;
      logic [DOUT_WIDTH-1:0]       w_sat;
      logic [DOUT_WIDTH-1:0]       r_dout;
      logic [1:0]                  w_warn;
      logic [1:0]                  r_warn;
      logic                        r_sticky;

      assign w_x = bus.din[gi*DIN_WIDTH +: DIN_WIDTH];

      if (S > 0) begin : g_round
        localparam logic [S-1:0] HALF = S'(1) << (S - 1);
        logic signed [IW-1:0] w_trunc;
        logic [S-1:0]         w_frac;
        logic                 w_up;

        assign w_trunc = IW'(w_x >>> S);
        assign w_frac  = w_x[S-1:0];
        // Convergent rounds an exact half only when the truncated result is odd.
        assign w_up = (ROUND_MODE == 1) ? (w_frac >= HALF) :
                      (ROUND_MODE == 2) ? ((w_frac > HALF) | ((w_frac == HALF) & w_trunc[0])) :
                      1'b0;
        assign w_aligned = w_trunc + IW'(w_up);
      end else begin : g_shift
        assign w_aligned = IW'(w_x) <<< (-S);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_val <= '0;
        end else if (w_en) begin
          r_s1_val <= w_aligned;
        end
      end

      assign w_v    = CW'(r_s1_val);
      assign w_hi   = w_v > MAX_V;
      assign w_lo   = w_v < MIN_V;
      assign w_sat  = w_hi ? MAX_V[DOUT_WIDTH-1:0] :
                      (w_lo ? MIN_V[DOUT_WIDTH-1:0] : w_v[DOUT_WIDTH-1:0]);
      assign w_warn = w_hi ? 2'd1 : (w_lo ? 2'd2 : 2'd0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout <= '0;
          r_warn <= 2'd0;
        end else if (w_en) begin
          r_dout <= w_sat;
          r_warn <= w_warn;
        end
      end

      // A clip leaving the block outranks a simultaneous clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sticky <= 1'b0;
        end else if (w_xfer_out && (r_warn != 2'd0)) begin
          r_sticky <= 1'b1;
        end else if (bus.ovf_clear) begin
          r_sticky <= 1'b0;
        end
      end

      assign bus.dout[gi*DOUT_WIDTH +: DOUT_WIDTH] = r_dout;
      assign bus.warning[2*gi +: 2]                = r_warn;
      assign bus.ovf_sticky[gi]                    = r_sticky;
    end
  endgenerate
endmodule

// File: tb/tb_signed_cast_round.sv
// Bench for signed_cast_round: seven single-lane configurations plus a four-lane
// instance, checked against an arithmetic reference model.
module tb_signed_cast_round;
  localparam int N = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tb_din;
  logic [63:0] tb_din4;
  logic        tb_valid;
  logic        tb_ready;
  logic        tb_clear;

  logic [23:0] o_dout [N];
  logic [1:0]  o_warn [N];
  logic        o_dv   [N];
  logic        o_rdy  [N];

  int checks = 0;
  int errors = 0;
  logic [15:0] inflight [$];

  always #5 clk = ~clk;

  // 0..2: Q4.12->Q4.4 modes 0/1/2; 3: mode 1 symmetric; 4..6: widening to 24b/16 frac, modes 0/1/2
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_dut
    localparam int DW = (gi >= 4) ? 24 : 8;
    localparam int DP = (gi >= 4) ? 16 : 4;
    localparam int RM = (gi < 3) ? gi : ((gi == 3) ? 1 : gi - 4);
    localparam int SY = (gi == 3) ? 1 : 0;
    signed_cast_round_if #(.DIN_WIDTH(16), .DOUT_WIDTH(DW), .CHANNELS(1)) bus ();
    assign bus.din        = tb_din;
    assign bus.din_valid  = tb_valid;
    assign bus.dout_ready = tb_ready;
    assign bus.ovf_clear  = tb_clear;
    signed_cast_round #(
      .DIN_WIDTH(16), .DIN_POINT(12), .DOUT_WIDTH(DW), .DOUT_POINT(DP),
      .CHANNELS(1), .ROUND_MODE(RM), .SYMMETRIC(SY)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    assign o_dout[gi] = 24'(bus.dout);
    assign o_warn[gi] = bus.warning;
    assign o_dv[gi]   = bus.dout_valid;
    assign o_rdy[gi]  = bus.din_ready;
  end

  signed_cast_round_if #(.DIN_WIDTH(16), .DOUT_WIDTH(8), .CHANNELS(4)) bus4 ();
  assign bus4.din        = tb_din4;
  assign bus4.din_valid  = tb_valid;
  assign bus4.dout_ready = tb_ready;
  assign bus4.ovf_clear  = tb_clear;
  signed_cast_round #(
    .DIN_WIDTH(16), .DIN_POINT(12), .DOUT_WIDTH(8), .DOUT_POINT(4),
    .CHANNELS(4), .ROUND_MODE(1), .SYMMETRIC(0)
  ) u_ch4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  // Reference: scale by 2^-S, round per mode, clamp to the output range.
  function automatic logic [25:0] model(input logic [15:0] x, input int k);
    int     dw, s, mode;
    bit     sym;
    longint v, q, r, half, maxv, minv, mask;
    logic [1:0] w;
    dw   = (k >= 4) ? 24 : 8;
    s    = 12 - ((k >= 4) ? 16 : 4);
    mode = (k < 3) ? k : ((k == 3) ? 1 : k - 4);
    sym  = (k == 3);
    v    = longint'($signed(x));
    if (s > 0) begin
      q    = v >>> s;
      r    = v - (q <<< s);
      half = longint'(1) <<< (s - 1);
      if (mode == 1 && r >= half) q = q + 1;
      else if (mode == 2 && (r > half || (r == half && q[0]))) q = q + 1;
    end else begin
      q = v <<< (-s);
    end
    maxv = (longint'(1) <<< (dw - 1)) - 1;
    minv = sym ? -maxv : -maxv - 1;
    w = 2'd0;
    if (q > maxv) begin q = maxv; w = 2'd1; end
    else if (q < minv) begin q = minv; w = 2'd2; end
    mask = (longint'(1) <<< dw) - 1;
    return {w, 24'(q & mask)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; tb_valid = 1'b0; tb_ready = 1'b1; tb_clear = 1'b0;
    tb_din = '0; tb_din4 = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_dv[k] !== 1'b0 || o_dout[k] !== 24'h0 || o_warn[k] !== 2'd0 || o_rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset k=%0d got dv=%b dout=%h warn=%0d rdy=%b exp dv=0 dout=0 warn=0 rdy=1",
                 k, o_dv[k], o_dout[k], o_warn[k], o_rdy[k]);
      end
    end
    checks++;
    if (bus4.dout_valid !== 1'b0 || bus4.dout !== 32'h0 || bus4.warning !== 8'h0 || bus4.ovf_sticky !== 4'h0) begin
      errors++;
      $display("FAIL reset_ch4 got dv=%b dout=%h warn=%h sticky=%h exp all zero",
               bus4.dout_valid, bus4.dout, bus4.warning, bus4.ovf_sticky);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] vecs [7] = '{16'h0180, 16'h0280, 16'hFE80, 16'h7FF0, 16'h8000, 16'hF800, 16'h7FFF};
    logic [7:0]  tbl [3][3] = '{'{8'h01, 8'h02, 8'h02}, '{8'h02, 8'h03, 8'h02}, '{8'hFE, 8'hFF, 8'hFE}};
    logic [25:0] e;
    tb_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      @(negedge clk); tb_din = vecs[v]; tb_valid = 1'b1;
      @(negedge clk); tb_valid = 1'b0;
      checks++;
      if (o_dv[0] !== 1'b0) begin
        errors++;
        $display("FAIL latency_early din=%h got dv=%b exp 0", vecs[v], o_dv[0]);
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        e = model(vecs[v], k);
        checks++;
        if (o_dv[k] !== 1'b1 || o_dout[k] !== e[23:0] || o_warn[k] !== e[25:24]) begin
          errors++;
          $display("FAIL directed din=%h k=%0d got dv=%b dout=%h warn=%0d exp dv=1 dout=%h warn=%0d",
                   vecs[v], k, o_dv[k], o_dout[k], o_warn[k], e[23:0], e[25:24]);
        end
      end
      if (v < 3) begin
        for (int m = 0; m < 3; m++) begin
          checks++;
          if (o_dout[m] !== {16'h0, tbl[v][m]} || o_warn[m] !== 2'd0) begin
            errors++;
            $display("FAIL round_table din=%h mode=%0d got dout=%h warn=%0d exp dout=%h warn=0",
                     vecs[v], m, o_dout[m], o_warn[m], tbl[v][m]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [25:0] e;
    logic [15:0] x;
    int got = 0;
    int sent = 0;
    inflight.delete();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      tb_valid = (c < 260) && ($urandom_range(3) != 0);
      tb_din   = 16'($urandom);
      if ($urandom_range(3) == 0) tb_din[15:8] = ($urandom_range(1) != 0) ? 8'h7F : 8'h80;
      tb_ready = ($urandom_range(4) != 0);
      #1;
      if (o_dv[0] && tb_ready) begin
        if (inflight.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand_unexpected got dout=%h exp no output", o_dout[0]);
        end else begin
          x = inflight.pop_front();
          got++;
          for (int k = 0; k < N; k++) begin
            e = model(x, k);
            checks++;
            if (o_dv[k] !== 1'b1 || o_dout[k] !== e[23:0] || o_warn[k] !== e[25:24]) begin
              errors++;
              $display("FAIL rand din=%h k=%0d got dout=%h warn=%0d exp dout=%h warn=%0d",
                       x, k, o_dout[k], o_warn[k], e[23:0], e[25:24]);
            end
          end
        end
      end
      if (tb_valid && o_rdy[0]) begin
        inflight.push_back(tb_din);
        sent++;
      end
    end
    checks++;
    if (inflight.size() != 0 || got != sent) begin
      errors++;
      $display("FAIL rand_count got %0d outputs exp %0d", got, sent);
    end
    tb_valid = 1'b0; tb_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0]  outs [$];
    logic [23:0] prev_dout = '0;
    logic        prev_stall = 1'b0;
    int          idx = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tb_ready = !(c >= 3 && c <= 5);
      tb_valid = (idx <= 5);
      tb_din   = 16'(idx << 8);
      #1;
      if (prev_stall) begin
        checks++;
        if (o_dv[0] !== 1'b1 || o_dout[0] !== prev_dout) begin
          errors++;
          $display("FAIL bp_hold cycle=%0d got dv=%b dout=%h exp dv=1 dout=%h", c, o_dv[0], o_dout[0], prev_dout);
        end
      end
      if (!tb_ready && o_dv[0]) begin
        checks++;
        if (o_rdy[0] !== 1'b0) begin
          errors++;
          $display("FAIL bp_din_ready cycle=%0d got %b exp 0", c, o_rdy[0]);
        end
      end
      if (o_dv[0] && tb_ready) outs.push_back(o_dout[0][7:0]);
      if (tb_valid && o_rdy[0]) idx++;
      prev_stall = o_dv[0] && !tb_ready;
      prev_dout  = o_dout[0];
    end
    checks++;
    if (outs.size() != 5) begin
      errors++;
      $display("FAIL bp_count got %0d exp 5", outs.size());
    end
    for (int i = 0; i < outs.size(); i++) begin
      checks++;
      if (outs[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL bp_order idx=%0d got %h exp %h", i, outs[i], 8'(i + 1));
      end
    end
    tb_valid = 1'b0; tb_ready = 1'b1;
  endtask

  task automatic test_multilane();
    logic [15:0] lanes [4] = '{16'h7FFF, 16'h8000, 16'h0100, 16'h0000};
    logic [31:0] exp_dout;
    logic [7:0]  exp_warn;
    logic [3:0]  exp_stk;
    logic [25:0] e;
    for (int l = 0; l < 4; l++) begin
      e = model(lanes[l], 1);
      exp_dout[8*l +: 8] = e[7:0];
      exp_warn[2*l +: 2] = e[25:24];
      exp_stk[l]         = (e[25:24] != 2'd0);
    end
    tb_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      tb_din4 = {lanes[3], lanes[2], lanes[1], lanes[0]}; tb_valid = 1'b1; tb_clear = (pass == 0);
      @(negedge clk); tb_valid = 1'b0; tb_clear = 1'b0;
      @(negedge clk);
      checks++;
      if (bus4.dout_valid !== 1'b1 || bus4.dout !== exp_dout || bus4.warning !== exp_warn) begin
        errors++;
        $display("FAIL lanes pass=%0d got dv=%b dout=%h warn=%h exp dv=1 dout=%h warn=%h",
                 pass, bus4.dout_valid, bus4.dout, bus4.warning, exp_dout, exp_warn);
      end
      tb_clear = (pass == 1);
      @(negedge clk);
      tb_clear = 1'b0;
      checks++;
      if (bus4.ovf_sticky !== exp_stk) begin
        errors++;
        $display("FAIL sticky pass=%0d got %b exp %b", pass, bus4.ovf_sticky, exp_stk);
      end
      if (pass == 0) begin
        tb_clear = 1'b1;
        @(negedge clk);
        tb_clear = 1'b0;
        checks++;
        if (bus4.ovf_sticky !== 4'b0000) begin
          errors++;
          $display("FAIL sticky_clear got %b exp 0000", bus4.ovf_sticky);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [25:0] e;
    tb_ready = 1'b1;
    @(negedge clk); tb_din = 16'h7FF0; tb_din4 = {4{16'h7FF0}}; tb_valid = 1'b1;
    @(negedge clk); tb_din = 16'h0300; tb_din4 = {4{16'h0300}};
    @(negedge clk); tb_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_dv[k] !== 1'b0 || o_dout[k] !== 24'h0 || o_warn[k] !== 2'd0) begin
        errors++;
        $display("FAIL midreset k=%0d got dv=%b dout=%h warn=%0d exp 0", k, o_dv[k], o_dout[k], o_warn[k]);
      end
    end
    checks++;
    if (bus4.dout_valid !== 1'b0 || bus4.dout !== 32'h0 || bus4.ovf_sticky !== 4'h0) begin
      errors++;
      $display("FAIL midreset_ch4 got dv=%b dout=%h sticky=%b exp 0", bus4.dout_valid, bus4.dout, bus4.ovf_sticky);
    end
    @(negedge clk); rst_n = 1'b1; tb_din = 16'h0280; tb_valid = 1'b1;
    @(negedge clk); tb_valid = 1'b0;
    checks++;
    if (o_dv[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early got dv=%b exp 0", o_dv[0]);
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      e = model(16'h0280, k);
      checks++;
      if (o_dv[k] !== 1'b1 || o_dout[k] !== e[23:0]) begin
        errors++;
        $display("FAIL post_reset k=%0d got dv=%b dout=%h exp dv=1 dout=%h", k, o_dv[k], o_dout[k], e[23:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_multilane();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
